// File: rtl/imem_loader_if.sv
// Byte-stream-in / IMEM-write-out bundle for imem_loader; checksum exists only with IMEM_LOADER_CHECKSUM_EN.
// master drives the load control and the byte stream; slave is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic [3:0]        imem_we;
    logic              busy;
    logic              done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;

    modport master (
        output start, base_addr, num_words, abort, byte_in, byte_valid,
        input  byte_ready, imem_addr, imem_din, imem_we, busy, done, checksum
    );
    modport slave (
        input  start, base_addr, num_words, abort, byte_in, byte_valid,
        output byte_ready, imem_addr, imem_din, imem_we, busy, done, checksum
    );
`else
    modport master (
        output start, base_addr, num_words, abort, byte_in, byte_valid,
        input  byte_ready, imem_addr, imem_din, imem_we, busy, done
    );
    modport slave (
        input  start, base_addr, num_words, abort, byte_in, byte_valid,
        output byte_ready, imem_addr, imem_din, imem_we, busy, done
    );
`endif
endinterface

// File: rtl/imem_loader.sv
// Purpose: packs little-endian stream bytes into 32-bit words written to IMEM from a base word address (IMEM_LOADER_CHECKSUM_EN adds a running word sum).
// Latency: write cycle follows the edge accepting byte 4; 5 cycles/word at full rate; done pulses the cycle after the last write.
// Backpressure: byte_ready is state-decoded (high only while collecting) and drops for the one write cycle per word.
module imem_loader #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
) (
    input  logic   clk,
    input  logic   rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_dat_q, wr_dat_d;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        accept    = (state_q == S_COLLECT) && bus.byte_valid;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    rem_d   = bus.num_words;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (bus.num_words == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    // The 4th byte goes straight into the write register so the word is ready in WRITE.
                    if (idx_q == 2'd3) begin
                        wr_addr_d = addr_q;
                        wr_dat_d  = {bus.byte_in, word_q};
                        state_d   = S_WRITE;
                    end else begin
                        case (idx_q)
                            2'd0:    word_d[7:0]   = bus.byte_in;
                            2'd1:    word_d[15:8]  = bus.byte_in;
                            default: word_d[23:16] = bus.byte_in;
                        endcase
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                idx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = csum_q + wr_dat_q;
`endif
                if (bus.abort)
                    state_d = S_IDLE;
                else if (rem_q == CNT_W'(1))
                    state_d = S_DONE;
                else
                    state_d = S_COLLECT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.byte_ready = (state_q == S_COLLECT);
    assign bus.imem_we    = (state_q == S_WRITE) ? 4'hF : 4'h0;
    assign bus.imem_addr  = wr_addr_q;
    assign bus.imem_din   = wr_dat_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.checksum   = csum_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes are derived from the byte list
// (word i = bytes 4i..4i+3 little-endian at base+i mod 2^14) and compared against an IMEM-port monitor.
module tb_imem_loader;
    localparam int AW = 14;
    localparam int CW = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW), .CNT_W(CW)) lif ();
    imem_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(lif.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_dat[$];
    logic [3:0]    obs_we[$];
    int            obs_cyc[$];
    logic [7:0]    stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lif.imem_we != 4'h0) begin
                obs_addr.push_back(lif.imem_addr);
                obs_dat.push_back(lif.imem_din);
                obs_we.push_back(lif.imem_we);
                obs_cyc.push_back(cyc);
            end
            if (lif.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_dat.delete();
        obs_we.delete();
        obs_cyc.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(negedge clk);
        lif.base_addr = b;
        lif.num_words = n;
        lif.start     = 1'b1;
        @(negedge clk);
        lif.start     = 1'b0;
    endtask

    // Offers stim bytes until stop_after of them have been handshaken.
    task automatic feed(input string tag, input bit toggle, input int stop_after);
        int i = 0;
        int g = 0;
        int target;
        bit ph = 1'b1;
        target = (stop_after < stim.size()) ? stop_after : stim.size();
        while (i < target && g < 2000) begin
            lif.byte_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            lif.byte_in = lif.byte_valid ? stim[i] : 8'($urandom);
            if (lif.byte_valid && lif.byte_ready) i++;
            @(negedge clk);
            g++;
        end
        lif.byte_valid = 1'b0;
        chk({tag, ".bytes_accepted"}, i, target);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (lif.busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({tag, ".idle"}, lif.busy, 1'b0);
    endtask

    task automatic check_writes(input string tag, input logic [AW-1:0] base, input int n);
        logic [31:0]   sum;
        logic [31:0]   ew;
        logic [AW-1:0] ea;
        sum = '0;
        chk({tag, ".count"}, obs_addr.size(), n);
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            ea  = base + AW'(i);
            ew  = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            sum = sum + ew;
            chk($sformatf("%s.addr%0d", tag, i), obs_addr[i], ea);
            chk($sformatf("%s.data%0d", tag, i), obs_dat[i], ew);
            chk($sformatf("%s.we%0d", tag, i), obs_we[i], 4'hF);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"}, lif.checksum, sum);
`endif
        clear_obs();
    endtask

    initial begin
        int d0;
        int n;
        logic [AW-1:0] b;
        bit tg;

        rst_n          = 1'b0;
        lif.start      = 1'b0;
        lif.base_addr  = '0;
        lif.num_words  = '0;
        lif.abort      = 1'b0;
        lif.byte_in    = '0;
        lif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.byte_ready", lif.byte_ready, 1'b0);
        chk("rst.imem_we", lif.imem_we, 4'h0);
        chk("rst.imem_addr", lif.imem_addr, '0);
        chk("rst.imem_din", lif.imem_din, '0);
        chk("rst.busy", lif.busy, 1'b0);
        chk("rst.done", lif.done, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("rst.checksum", lif.checksum, '0);
`endif

        // Idle with valid bytes but no start: nothing accepted, nothing written.
        rst_n          = 1'b1;
        lif.byte_valid = 1'b1;
        lif.byte_in    = 8'hAA;
        repeat (6) @(negedge clk);
        chk("idle.byte_ready", lif.byte_ready, 1'b0);
        chk("idle.busy", lif.busy, 1'b0);
        chk("idle.writes", obs_addr.size(), 0);
        chk("idle.done", done_cnt, 0);
        lif.byte_valid = 1'b0;

        // Basic two-word load at full byte rate.
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        d0 = done_cnt;
        do_start(14'h0010, 15'd2);
        chk("basic.busy_after_start", lif.busy, 1'b1);
        feed("basic", 1'b0, 99);
        wait_idle("basic");
        if (obs_cyc.size() >= 2) begin
            chk("basic.cycles_per_word", obs_cyc[1] - obs_cyc[0], 5);
            chk("basic.done_after_last_write", done_cyc, obs_cyc[1] + 1);
        end
        chk("basic.word0_literal", (obs_dat.size() > 0) ? obs_dat[0] : 32'h0, 32'h12345678);
        check_writes("basic", 14'h0010, 2);
        chk("basic.done_pulses", done_cnt, d0 + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("basic.checksum_literal", lif.checksum, 32'hF0E21567);
`endif

        // Wrap, toggling valid, and a start pulse that must be ignored mid-load.
        for (int k = 0; k < 8; k++) stim[k] = 8'($urandom);
        d0 = done_cnt;
        do_start(14'h3FFF, 15'd2);
        lif.base_addr = 14'h0100;
        lif.num_words = 15'd5;
        lif.start     = 1'b1;
        @(negedge clk);
        lif.start     = 1'b0;
        feed("wrap", 1'b1, 99);
        wait_idle("wrap");
        check_writes("wrap", 14'h3FFF, 2);
        chk("wrap.done_pulses", done_cnt, d0 + 1);

        // Zero-length load.
        d0 = done_cnt;
        do_start(14'h0123, 15'd0);
        chk("zero.done_t1", lif.done, 1'b1);
        chk("zero.busy_t1", lif.busy, 1'b1);
        @(negedge clk);
        chk("zero.done_t2", lif.done, 1'b0);
        chk("zero.busy_t2", lif.busy, 1'b0);
        chk("zero.writes", obs_addr.size(), 0);
        chk("zero.done_pulses", done_cnt, d0 + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero.checksum", lif.checksum, '0);
`endif

        // Abort after six bytes of a three-word load.
        stim.delete();
        for (int k = 0; k < 12; k++) stim.push_back(8'($urandom));
        d0 = done_cnt;
        do_start(14'h0040, 15'd3);
        feed("abort", 1'b0, 6);
        lif.abort = 1'b1;
        @(negedge clk);
        lif.abort = 1'b0;
        chk("abort.busy", lif.busy, 1'b0);
        repeat (3) @(negedge clk);
        check_writes("abort", 14'h0040, 1);
        chk("abort.no_done", done_cnt, d0);

        stim.delete();
        for (int k = 0; k < 4; k++) stim.push_back(8'($urandom));
        do_start(14'h0050, 15'd1);
        feed("post_abort", 1'b0, 99);
        wait_idle("post_abort");
        check_writes("post_abort", 14'h0050, 1);
        chk("post_abort.done_pulses", done_cnt, d0 + 1);

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            b  = AW'($urandom);
            n  = $urandom_range(1, 4);
            tg = 1'($urandom);
            stim.delete();
            for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
            d0 = done_cnt;
            do_start(b, CW'(n));
            feed($sformatf("rand%0d", r), tg, 99);
            wait_idle($sformatf("rand%0d", r));
            check_writes($sformatf("rand%0d", r), b, n);
            chk($sformatf("rand%0d.done_pulses", r), done_cnt, d0 + 1);
        end

        // Reset asserted during the WRITE cycle.
        stim.delete();
        for (int k = 0; k < 4; k++) stim.push_back(8'($urandom));
        d0 = done_cnt;
        do_start(14'h0007, 15'd1);
        feed("rstmid", 1'b0, 99);
        chk("rstmid.we_before", lif.imem_we, 4'hF);
        rst_n = 1'b0;
        #1;
        chk("rstmid.we_in_reset", lif.imem_we, 4'h0);
        chk("rstmid.busy_in_reset", lif.busy, 1'b0);
        chk("rstmid.addr_in_reset", lif.imem_addr, '0);
        chk("rstmid.din_in_reset", lif.imem_din, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("rstmid.checksum_in_reset", lif.checksum, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("rstmid.busy_after", lif.busy, 1'b0);
        chk("rstmid.ready_after", lif.byte_ready, 1'b0);
        chk("rstmid.writes_after", obs_addr.size(), 0);
        chk("rstmid.no_done", done_cnt, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
